l2_port_arbiter: RTL and testbench

Two-requester arbiter between the L1 caches and the single L2 request port. It sits directly downstream of the dcache's L2-side port and the icache's L2-side port, and selects one outstanding request at a time. It drives that request onto the L2 interface and routes the L2 response back to the requester that owns it. Arbitration is round-robin, and each grant is held until L2 fulfils the request.

---
 rtl/l2_port_arbiter.sv | 139 +++++++++++++
 tb/tb_l2_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter between the icache and dcache L2 request ports; a grant is held until L2 completes.
// An IDLE-cycle request drives L2 next cycle; requesters are held off by keeping their valid until fulfilled.
package l2_port_arbiter_pkg;
    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } memory_operation_e;
endpackage

module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [XLEN-1:0]      ic_req_address,
    input  logic                 ic_req_valid,
    output logic [XLEN-1:0]      ic_fetched_word,
    output logic                 ic_req_fulfilled,

    input  logic [XLEN-1:0]      dc_req_address,
    input  memory_operation_e    dc_req_type,
    input  logic                 dc_req_valid,
    input  logic [XLEN-1:0]      dc_word_to_store,
    output logic [XLEN-1:0]      dc_fetched_word,
    output logic                 dc_req_fulfilled,

    output logic [XLEN-1:0]      l2_req_address,
    output memory_operation_e    l2_req_type,
    output logic                 l2_req_valid,
    output logic [XLEN-1:0]      l2_word_to_store,
    input  logic [XLEN-1:0]      l2_fetched_word,
    input  logic                 l2_req_fulfilled,

    output logic [CNT_WIDTH-1:0] contention_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2
    } state_e;

    localparam logic                 SERVED_IC = 1'b0;
    localparam logic                 SERVED_DC = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state;
    state_e               state_next;
    logic                 last_grant;
    logic                 last_grant_next;
    logic                 tie;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= SERVED_IC;
            cnt        <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            if (tie && (cnt != '1)) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // On a tie the requester that was not served last wins, so neither can starve.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        tie             = 1'b0;
        case (state)
            IDLE: begin
                if (ic_req_valid && dc_req_valid) begin
                    tie        = 1'b1;
                    state_next = (last_grant == SERVED_IC) ? GRANT_DC : GRANT_IC;
                end else if (ic_req_valid) begin
                    state_next = GRANT_IC;
                end else if (dc_req_valid) begin
                    state_next = GRANT_DC;
                end
            end
            GRANT_IC: begin
                if (l2_req_fulfilled) begin
                    state_next      = IDLE;
                    last_grant_next = SERVED_IC;
                end
            end
            GRANT_DC: begin
                if (l2_req_fulfilled) begin
                    state_next      = IDLE;
                    last_grant_next = SERVED_DC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Completions are masked while reset is high so an in-flight response never reaches a requester.
    always_comb begin
        l2_req_valid     = 1'b0;
        l2_req_address   = '0;
        l2_req_type      = MEM_LOAD;
        l2_word_to_store = '0;
        ic_req_fulfilled = 1'b0;
        ic_fetched_word  = '0;
        dc_req_fulfilled = 1'b0;
        dc_fetched_word  = '0;
        case (state)
            GRANT_IC: begin
                l2_req_valid   = 1'b1;
                l2_req_address = ic_req_address;
                if (l2_req_fulfilled && !reset) begin
                    ic_req_fulfilled = 1'b1;
                    ic_fetched_word  = l2_fetched_word;
                end
            end
            GRANT_DC: begin
                l2_req_valid     = 1'b1;
                l2_req_address   = dc_req_address;
                l2_req_type      = dc_req_type;
                l2_word_to_store = dc_word_to_store;
                if (l2_req_fulfilled && !reset) begin
                    dc_req_fulfilled = 1'b1;
                    dc_fetched_word  = l2_fetched_word;
                end
            end
            default: ;
        endcase
    end

    assign contention_count = cnt;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized bench for l2_port_arbiter: transaction-level arbitration model with a grant scoreboard.
module tb_l2_port_arbiter;
    import l2_port_arbiter_pkg::*;

    localparam int XLEN = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [XLEN-1:0]   addr;
        memory_operation_e typ;
        logic [XLEN-1:0]   wdata;
    } req_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [XLEN-1:0]   ic_req_address = '0;
    logic              ic_req_valid = 1'b0;
    logic [XLEN-1:0]   ic_fetched_word;
    logic              ic_req_fulfilled;
    logic [XLEN-1:0]   dc_req_address = '0;
    memory_operation_e dc_req_type = MEM_LOAD;
    logic              dc_req_valid = 1'b0;
    logic [XLEN-1:0]   dc_word_to_store = '0;
    logic [XLEN-1:0]   dc_fetched_word;
    logic              dc_req_fulfilled;
    logic [XLEN-1:0]   l2_req_address;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic [XLEN-1:0]   l2_word_to_store;
    logic [XLEN-1:0]   l2_fetched_word = '0;
    logic              l2_req_fulfilled = 1'b0;
    logic [CW-1:0]     contention_count;

    l2_port_arbiter #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .ic_req_address   (ic_req_address),
        .ic_req_valid     (ic_req_valid),
        .ic_fetched_word  (ic_fetched_word),
        .ic_req_fulfilled (ic_req_fulfilled),
        .dc_req_address   (dc_req_address),
        .dc_req_type      (dc_req_type),
        .dc_req_valid     (dc_req_valid),
        .dc_word_to_store (dc_word_to_store),
        .dc_fetched_word  (dc_fetched_word),
        .dc_req_fulfilled (dc_req_fulfilled),
        .l2_req_address   (l2_req_address),
        .l2_req_type      (l2_req_type),
        .l2_req_valid     (l2_req_valid),
        .l2_word_to_store (l2_word_to_store),
        .l2_fetched_word  (l2_fetched_word),
        .l2_req_fulfilled (l2_req_fulfilled),
        .contention_count (contention_count)
    );

    initial forever #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   run = 1'b0;
    bit   mon_en = 1'b0;
    bit   l2_auto = 1'b0;
    bit   ic_busy = 1'b0;
    bit   dc_busy = 1'b0;
    req_t ic_q[$];
    req_t dc_q[$];

    // Reference model: owner 0 = none, 1 = IC, 2 = DC.
    int   m_owner = 0;
    int   m_last  = 1;
    int   m_cnt   = 0;
    int   n_ties  = 0;
    int   n_txn   = 0;
    req_t m_cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // icache requester: loads only, holds request until it sees fulfilled.
    initial begin : ic_driver
        int   gap;
        int   n;
        req_t r;
        forever begin
            if (!run) begin
                @(posedge clk); #1;
            end else begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin @(posedge clk); #1; end
                r.addr  = $urandom;
                r.typ   = MEM_LOAD;
                r.wdata = '0;
                ic_req_address = r.addr;
                ic_req_valid   = 1'b1;
                ic_busy        = 1'b1;
                ic_q.push_back(r);
                n = 0;
                do begin @(negedge clk); #3; n++; end while (!ic_req_fulfilled && n < 300);
                if (!ic_req_fulfilled) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ic_timeout: got no fulfilled, expected one within 300 cycles");
                end
                @(posedge clk); #1;
                ic_req_valid = 1'b0;
                ic_busy      = 1'b0;
            end
        end
    end

    // dcache requester: random loads and stores.
    initial begin : dc_driver
        int   gap;
        int   n;
        req_t r;
        forever begin
            if (!run) begin
                @(posedge clk); #1;
            end else begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin @(posedge clk); #1; end
                r.addr  = $urandom;
                r.typ   = ($urandom_range(0, 1) == 1) ? MEM_STORE : MEM_LOAD;
                r.wdata = $urandom;
                dc_req_address   = r.addr;
                dc_req_type      = r.typ;
                dc_word_to_store = r.wdata;
                dc_req_valid     = 1'b1;
                dc_busy          = 1'b1;
                dc_q.push_back(r);
                n = 0;
                do begin @(negedge clk); #3; n++; end while (!dc_req_fulfilled && n < 300);
                if (!dc_req_fulfilled) begin
                    n_cmp++; n_bad++;
                    $display("FAIL dc_timeout: got no fulfilled, expected one within 300 cycles");
                end
                @(posedge clk); #1;
                dc_req_valid = 1'b0;
                dc_busy      = 1'b0;
            end
        end
    end

    // L2 responder: 0-3 extra cycles of latency, garbage data when idle, spurious strobes in IDLE.
    initial begin : l2_model
        int wait_cnt = 0;
        bit in_txn   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (l2_auto) begin
                l2_req_fulfilled = 1'b0;
                l2_fetched_word  = $urandom;
                if (l2_req_valid) begin
                    if (!in_txn) begin
                        in_txn   = 1'b1;
                        wait_cnt = $urandom_range(0, 3);
                    end
                    if (wait_cnt == 0) begin
                        l2_req_fulfilled = 1'b1;
                        in_txn           = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end else begin
                    in_txn = 1'b0;
                    if ($urandom_range(0, 7) == 0) l2_req_fulfilled = 1'b1;
                end
            end
        end
    end

    // Monitor/scoreboard: pending requests come from the driver queues, not from DUT pins.
    initial begin : monitor
        bit ic_p;
        bit dc_p;
        forever begin
            @(negedge clk); #2;
            if (mon_en) begin
                chk("contention_count", 64'(contention_count), 64'(m_cnt));
                if (m_owner == 0) begin
                    chk("idle_l2_valid", 64'(l2_req_valid), 64'd0);
                    chk("idle_ic_fulfilled", 64'(ic_req_fulfilled), 64'd0);
                    chk("idle_dc_fulfilled", 64'(dc_req_fulfilled), 64'd0);
                    chk("idle_ic_word", 64'(ic_fetched_word), 64'd0);
                    chk("idle_dc_word", 64'(dc_fetched_word), 64'd0);
                    ic_p = (ic_q.size() > 0);
                    dc_p = (dc_q.size() > 0);
                    if (ic_p && dc_p) begin
                        m_owner = (m_last == 1) ? 2 : 1;
                        n_ties++;
                        if (m_cnt < CMAX) m_cnt++;
                    end else if (ic_p) begin
                        m_owner = 1;
                    end else if (dc_p) begin
                        m_owner = 2;
                    end
                    if (m_owner == 1) m_cur = ic_q.pop_front();
                    if (m_owner == 2) m_cur = dc_q.pop_front();
                end else begin
                    chk("grant_l2_valid", 64'(l2_req_valid), 64'd1);
                    chk("grant_l2_addr", 64'(l2_req_address), 64'(m_cur.addr));
                    chk("grant_l2_type", 64'(l2_req_type), 64'(m_cur.typ));
                    chk("grant_l2_wdata", 64'(l2_word_to_store), 64'(m_cur.wdata));
                    if (l2_req_fulfilled) begin
                        chk("done_ic_fulfilled", 64'(ic_req_fulfilled), 64'(m_owner == 1));
                        chk("done_dc_fulfilled", 64'(dc_req_fulfilled), 64'(m_owner == 2));
                        chk("done_ic_word", 64'(ic_fetched_word),
                            (m_owner == 1) ? 64'(l2_fetched_word) : 64'd0);
                        chk("done_dc_word", 64'(dc_fetched_word),
                            (m_owner == 2) ? 64'(l2_fetched_word) : 64'd0);
                        m_last  = m_owner;
                        m_owner = 0;
                        n_txn++;
                    end else begin
                        chk("wait_ic_fulfilled", 64'(ic_req_fulfilled), 64'd0);
                        chk("wait_dc_fulfilled", 64'(dc_req_fulfilled), 64'd0);
                        chk("wait_ic_word", 64'(ic_fetched_word), 64'd0);
                        chk("wait_dc_word", 64'(dc_fetched_word), 64'd0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish before 400000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_l2_valid", 64'(l2_req_valid), 64'd0);
        chk("rst_l2_addr", 64'(l2_req_address), 64'd0);
        chk("rst_l2_type", 64'(l2_req_type), 64'(MEM_LOAD));
        chk("rst_l2_wdata", 64'(l2_word_to_store), 64'd0);
        chk("rst_count", 64'(contention_count), 64'd0);
        chk("rst_ic_fulfilled", 64'(ic_req_fulfilled), 64'd0);
        chk("rst_dc_fulfilled", 64'(dc_req_fulfilled), 64'd0);

        reset   = 1'b0;
        m_owner = 0;
        m_last  = 1;
        m_cnt   = 0;
        mon_en  = 1'b1;
        l2_auto = 1'b1;
        run     = 1'b1;
        repeat (3000) @(posedge clk);
        #1;
        run = 1'b0;
        n = 0;
        while ((ic_busy || dc_busy || m_owner != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got requests still pending, expected drained within 500 cycles");
        end
        chk("count_saturated", 64'(contention_count), (n_ties > CMAX) ? 64'(CMAX) : 64'(n_ties));
        chk("queues_empty", 64'(ic_q.size() + dc_q.size()), 64'd0);

        // Reset lands on the same cycle L2 completes a DC grant that won a tie.
        @(negedge clk);
        mon_en  = 1'b0;
        l2_auto = 1'b0;
        @(posedge clk); #1;
        l2_req_fulfilled = 1'b0;
        reset            = 1'b1;
        @(posedge clk); #1;
        reset            = 1'b0;
        ic_req_address   = 32'h0000_1000;
        ic_req_valid     = 1'b1;
        dc_req_address   = 32'h0000_2000;
        dc_req_type      = MEM_STORE;
        dc_word_to_store = 32'h1234_5678;
        dc_req_valid     = 1'b1;
        @(posedge clk); #1;
        chk("tie_count_one", 64'(contention_count), 64'd1);
        chk("tie_dc_first_addr", 64'(l2_req_address), 64'h2000);
        chk("tie_dc_first_type", 64'(l2_req_type), 64'(MEM_STORE));
        chk("tie_dc_first_wdata", 64'(l2_word_to_store), 64'h1234_5678);
        l2_fetched_word  = 32'hCAFE_F00D;
        l2_req_fulfilled = 1'b1;
        reset            = 1'b1;
        #1;
        chk("rst_blocks_dc_fulfilled", 64'(dc_req_fulfilled), 64'd0);
        chk("rst_blocks_dc_word", 64'(dc_fetched_word), 64'd0);
        chk("rst_blocks_ic_fulfilled", 64'(ic_req_fulfilled), 64'd0);
        @(posedge clk); #1;
        chk("post_rst_l2_valid", 64'(l2_req_valid), 64'd0);
        chk("post_rst_count", 64'(contention_count), 64'd0);
        reset            = 1'b0;
        l2_req_fulfilled = 1'b0;
        ic_req_valid     = 1'b0;
        dc_req_valid     = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
